// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// Module   : ram_arbiter_pkg
// Brief    : Shared types and constants for the IF/MEM SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_t;

    localparam int          c_RAM_ADDR_W = 30;
    localparam int          c_CNT_W      = 4;
    localparam logic [3:0]  c_IF_BE      = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Brief    : Fixed-priority, non-preemptive arbiter sharing one SRAM between
//            instruction fetch (read-only) and the MEM stage (loads/stores).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2       // SRAM cycles per access, 2..15
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     if_ce_i,
    input  logic [31:0]              if_addr_i,
    output logic [31:0]              if_data_o,
    output logic                     if_ready_o,

    input  logic                     mem_ce_i,
    input  logic                     mem_we_i,
    input  logic [3:0]               mem_sel_i,
    input  logic [31:0]              mem_addr_i,
    input  logic [31:0]              mem_data_i,
    output logic [31:0]              mem_data_o,
    output logic                     mem_ready_o,

    output logic                     ram_ce_o,
    output logic                     ram_oe_o,
    output logic                     ram_we_o,
    output logic [3:0]               ram_be_o,
    output logic [c_RAM_ADDR_W-1:0]  ram_addr_o,
    output logic [31:0]              ram_wdata_o,
    input  logic [31:0]              ram_rdata_i
);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WAIT_CYCLES - 1);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt;
    owner_t                  r_owner;
    logic [c_RAM_ADDR_W-1:0] r_addr;
    logic                    r_we;
    logic [3:0]              r_be;
    logic [31:0]             r_wdata;
    logic [31:0]             r_if_data;
    logic [31:0]             r_mem_data;

    logic                    w_access;
    logic                    w_last;
    logic                    w_done;
    logic                    w_unused_addr_bits;

    assign w_access = (r_state == ARB_ACCESS);
    assign w_done   = (r_state == ARB_DONE);
    assign w_last   = (r_cnt == '0);

    // Byte-address low bits carry no information for a word-wide SRAM.
    assign w_unused_addr_bits = ^{if_addr_i[1:0], mem_addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DONE never samples requests so a requester still holding ce during
    // its ready cycle cannot trigger a duplicate access.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:   if (mem_ce_i || if_ce_i) w_state_nxt = ARB_ACCESS;
            ARB_ACCESS: if (w_last)              w_state_nxt = ARB_DONE;
            ARB_DONE:                            w_state_nxt = ARB_IDLE;
            default:                             w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_owner    <= OWNER_IF;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_if_data  <= '0;
            r_mem_data <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (mem_ce_i) begin
                        r_owner <= OWNER_MEM;
                        r_addr  <= mem_addr_i[31:2];
                        r_we    <= mem_we_i;
                        r_be    <= mem_sel_i;
                        r_wdata <= mem_data_i;
                        r_cnt   <= c_CNT_LOAD;
                    end else if (if_ce_i) begin
                        r_owner <= OWNER_IF;
                        r_addr  <= if_addr_i[31:2];
                        r_we    <= 1'b0;
                        r_be    <= c_IF_BE;
                        r_wdata <= '0;
                        r_cnt   <= c_CNT_LOAD;
                    end
                end
                ARB_ACCESS: begin
                    if (w_last) begin
                        if (!r_we) begin
                            if (r_owner == OWNER_IF) r_if_data  <= ram_rdata_i;
                            else                     r_mem_data <= ram_rdata_i;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write strobe drops in the final ACCESS cycle to give address/data hold.
    assign ram_ce_o    = w_access;
    assign ram_oe_o    = w_access && !r_we;
    assign ram_we_o    = w_access && r_we && !w_last;
    assign ram_be_o    = w_access ? r_be    : '0;
    assign ram_addr_o  = w_access ? r_addr  : '0;
    assign ram_wdata_o = w_access ? r_wdata : '0;

    assign if_ready_o  = w_done && (r_owner == OWNER_IF);
    assign mem_ready_o = w_done && (r_owner == OWNER_MEM);
    assign if_data_o   = r_if_data;
    assign mem_data_o  = r_mem_data;

endmodule

`default_nettype wire
